apb_protocol_checker: RTL
=========================

Name: apb_protocol_checker

Overview:
- Synthesizable, passive APB4 protocol checker and transfer counter, parametrised in address width, data width, timeout and counter width.
- Taps an APB bus alongside the requester and completer; drives nothing onto the bus.
- Tracks each transfer with a SETUP/ACCESS state machine, raises sticky per-rule error flags and counts completed reads, writes and slave errors.
- Used in the FIFO/register subsystem for silicon-side bus debug and as an in-bench hardware assertion unit.

Parameters:
ADDR_W, 32, PADDR width
DATA_W, 32, PWDATA/PRDATA width (8, 16 or 32); PSTRB width is DATA_W/8
TIMEOUT, 16, max PREADY-low ACCESS cycles before the timeout error (1..255)
CNT_W, 16, width of each saturating transfer counter

Ports:
PCLK  in  1  clock
PRESETn  in  1  synchronous active-low reset
PADDR  in  ADDR_W  bus address
PPROT  in  3  protection
PSEL  in  1  select
PENABLE  in  1  enable
PWRITE  in  1  direction
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  write strobes
PREADY  in  1  completer ready
PSLVERR  in  1  completer error
clr  in  1  synchronous clear of flags, counters and err_addr
err_flags  out  5  sticky flags: [0] bad sequence, [1] enable without setup, [2] stability, [3] timeout, [4] strobe on read
err_pulse  out  1  one-cycle pulse when any flag bit sets in this cycle
wr_cnt  out  CNT_W  completed writes
rd_cnt  out  CNT_W  completed reads
slverr_cnt  out  CNT_W  completions with PSLVERR=1
err_addr  out  ADDR_W  captured PADDR of the most recent violation
busy  out  1  high while in SETUP or ACCESS

Behaviour:
- Reset: PRESETn low on a PCLK edge sets state=IDLE. All outputs are 0, wait counter 0, captured registers 0.
- Reset mid-transfer abandons the transfer with no flag and no count.
- All outputs are registered. A violation sampled at edge N is visible after edge N.
- IDLE:
  - PSEL & !PENABLE: capture PADDR, PPROT, PWRITE, PWDATA, PSTRB; go to SETUP.
  - PSEL & PENABLE: set flag[1]; stay in IDLE.
- SETUP (lasts exactly one cycle):
  - PSEL & PENABLE: go to ACCESS with wait counter = 0.
  - Otherwise: set flag[0]. If PSEL & !PENABLE, recapture and stay in SETUP; else go to IDLE.
- ACCESS, evaluated every cycle:
  - Stability check: compare PADDR, PPROT, PWRITE and PSTRB against the captured values; also PWDATA when the captured PWRITE=1. Any mismatch sets flag[2] (at most once per transfer).
  - Strobe check: captured PWRITE=0 with captured PSTRB!=0 sets flag[4] once, in the first ACCESS cycle.
  - !PSEL or !PENABLE: set flag[0]; transfer is aborted and not counted; go to IDLE.
  - PREADY=1: completion. Increment wr_cnt or rd_cnt per the captured PWRITE; also increment slverr_cnt if PSLVERR=1; go to IDLE.
  - PREADY=0: increment the wait counter, saturating at 255. When it reaches TIMEOUT, set flag[3] once per transfer and stay in ACCESS.
- Back-to-back transfers: the cycle after completion is evaluated as IDLE, so PSEL=1, PENABLE=0 there starts a new SETUP with no error.
- PSLVERR outside a completion cycle is ignored.
- Counters saturate at all-ones; they never wrap.
- err_addr takes the captured address for flags [0], [2], [3], [4], and the live PADDR for flag [1].
- If several flags set in one cycle: all of them set, err_pulse=1, and err_addr takes the value for the lowest-numbered flag.
- clr:
  - Zeroes flags, counters and err_addr; the state machine is unaffected.
  - An error or completion in the same cycle as clr wins: the flag sets, or the counter becomes 1.

Test Plan:
- Write 0x10 data 0xA5A5A5A5 PSTRB=0xF, 0 waits; then read 0x14 with PREADY low 3 cycles -> wr_cnt=1, rd_cnt=1, err_flags=0, busy high 2 then 5 cycles.
- PADDR changes from 0x20 to 0x24 in the second ACCESS wait cycle -> err_flags=5'b00100, err_pulse one cycle, err_addr=0x20, transfer still counted on PREADY.
- PREADY held low for 20 cycles with TIMEOUT=16 -> flag[3] sets on the 16th wait cycle, single err_pulse, rd_cnt increments at completion.
- PSEL=PENABLE=1 from IDLE at PADDR 0x30 -> flag[1], err_addr=0x30; separately, SETUP followed by PSEL=0 -> flag[0], no count.
- Read with PSTRB=0x3 completing with PSLVERR=1 -> flag[4], rd_cnt=1, slverr_cnt=1.
- CNT_W=4: 17 writes -> wr_cnt saturates at 15. clr coincident with a write completion -> wr_cnt=1. PRESETn low during ACCESS -> all outputs 0, busy=0 next cycle.

Source files
------------

// File: rtl/apb_protocol_checker.sv
// Passive APB4 protocol checker: phase tracking, sticky rule flags
// and saturating transfer counters. Drives nothing onto the bus.
module apb_protocol_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [2:0]          PPROT,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    input  logic                PREADY,
    input  logic                PSLVERR,
    input  logic                clr,
    output logic [4:0]          err_flags,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    slverr_cnt,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                busy
);

    localparam int         STRB_W = DATA_W / 8;
    localparam logic [7:0] TO     = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_prot;
    logic              cap_write;
    logic [DATA_W-1:0] cap_wdata;
    logic [STRB_W-1:0] cap_strb;

    logic [7:0] wait_cnt;
    logic [7:0] wait_cur;
    logic [7:0] wait_inc;
    logic [7:0] wait_nxt;
    logic       stab_done;
    logic       stab_cur;
    logic       stab_nxt;

    logic       sel_setup;
    logic       sel_access;
    logic       acc;
    logic       unstable;
    logic       cap_ld;
    logic       cur_busy;
    logic       cmp_wr;
    logic       cmp_rd;
    logic       cmp_err;
    logic [4:0] ev;
    logic [4:0] flags_base;

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v,
        input logic             inc
    );
        return (inc && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    assign sel_setup  = PSEL & ~PENABLE;
    assign sel_access = PSEL & PENABLE;

    // The cycle after SETUP with PENABLE high is itself the first ACCESS cycle
    assign acc = (state == SETUP && sel_access) || state == ACCESS;

    assign wait_cur = (state == ACCESS) ? wait_cnt : 8'd0;
    assign stab_cur = (state == ACCESS) && stab_done;
    assign wait_inc = (wait_cur == 8'hFF) ? wait_cur : wait_cur + 8'd1;

    assign unstable = (PADDR  != cap_addr)  ||
                      (PPROT  != cap_prot)  ||
                      (PWRITE != cap_write) ||
                      (PSTRB  != cap_strb)  ||
                      (cap_write && PWDATA != cap_wdata);

    assign flags_base = clr ? 5'd0 : err_flags;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (sel_setup) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (sel_access) begin
                    state_nxt = PREADY ? IDLE : ACCESS;
                end else if (sel_setup) begin
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (!sel_access || PREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ev       = '0;
        cap_ld   = 1'b0;
        cur_busy = 1'b0;
        cmp_wr   = 1'b0;
        cmp_rd   = 1'b0;
        cmp_err  = 1'b0;
        wait_nxt = wait_cur;
        stab_nxt = stab_cur;
        unique case (state)
            IDLE: begin
                cap_ld   = sel_setup;
                cur_busy = sel_setup;
                ev[1]    = sel_access;
            end
            SETUP: begin
                if (!sel_access) begin
                    ev[0]    = 1'b1;
                    cap_ld   = sel_setup;
                    cur_busy = sel_setup;
                end
            end
            default: ;
        endcase
        if (acc) begin
            if (unstable && !stab_cur) begin
                ev[2]    = 1'b1;
                stab_nxt = 1'b1;
            end
            if (state == SETUP && !cap_write && |cap_strb) begin
                ev[4] = 1'b1;
            end
            if (!sel_access) begin
                ev[0] = 1'b1;
            end else begin
                cur_busy = 1'b1;
                if (PREADY) begin
                    cmp_wr  = cap_write;
                    cmp_rd  = ~cap_write;
                    cmp_err = PSLVERR;
                end else begin
                    wait_nxt = wait_inc;
                    ev[3]    = (wait_cur < TO) && (wait_inc == TO);
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cap_addr   <= '0;
            cap_prot   <= '0;
            cap_write  <= 1'b0;
            cap_wdata  <= '0;
            cap_strb   <= '0;
            wait_cnt   <= '0;
            stab_done  <= 1'b0;
            err_flags  <= '0;
            err_pulse  <= 1'b0;
            err_addr   <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            slverr_cnt <= '0;
            busy       <= 1'b0;
        end else begin
            if (cap_ld) begin
                cap_addr  <= PADDR;
                cap_prot  <= PPROT;
                cap_write <= PWRITE;
                cap_wdata <= PWDATA;
                cap_strb  <= PSTRB;
            end
            wait_cnt  <= wait_nxt;
            stab_done <= stab_nxt;
            err_flags <= flags_base | ev;
            err_pulse <= |(ev & ~flags_base);
            // Only flag[1] can be raised in IDLE, so no other flag competes
            if (|ev) begin
                err_addr <= ev[1] ? PADDR : cap_addr;
            end else if (clr) begin
                err_addr <= '0;
            end
            wr_cnt     <= bump(clr ? '0 : wr_cnt, cmp_wr);
            rd_cnt     <= bump(clr ? '0 : rd_cnt, cmp_rd);
            slverr_cnt <= bump(clr ? '0 : slverr_cnt, cmp_err);
            busy       <= cur_busy;
        end
    end

endmodule
